// File: rtl/des_pkg.sv
// Shared constants and types for the iterative DES key schedule:
// rotation schedule, PC-1/PC-2 tables and half-register rotate helpers.
package des_pkg;

    typedef logic [47:0] round_key_t;
    typedef logic [27:0] half_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Entries are DES bit numbers (1 = MSB of the key).
    localparam logic [5:0] PC1_TBL [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // PC-1: 64-bit key to {C0, D0}; parity bits simply never get selected.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        logic [5:0]  pos;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            pos = 6'd63 - (PC1_TBL[i] - 6'd1);
            cd[55 - i] = key[pos];
        end
        return cd;
    endfunction

    function automatic half_t rotl28(input half_t h, input logic [1:0] amt);
        half_t r;
        case (amt)
            2'd2:    r = {h[25:0], h[27:26]};
            default: r = {h[26:0], h[27]};
        endcase
        return r;
    endfunction

`ifdef DES_KEY_DECRYPT_EN
    function automatic half_t rotr28(input half_t h, input logic [1:0] amt);
        half_t r;
        case (amt)
            2'd2:    r = {h[1:0], h[27:2]};
            default: r = {h[0], h[27:1]};
        endcase
        return r;
    endfunction
`endif

endpackage

// File: rtl/des_key_pc2.sv
// Combinational PC-2 permutation: 56-bit {C, D} to a 48-bit DES round key.
module des_key_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output round_key_t  rk_o
);

    logic [5:0] pos_s;

    // Table-driven bit selection; bit 47 of the result is DES bit 1.
    always_comb begin
        rk_o  = '0;
        pos_s = '0;
        for (int i = 0; i < 48; i++) begin
            pos_s = 6'd55 - (PC2_TBL[i] - 6'd1);
            rk_o[47 - i] = cd_i[pos_s];
        end
    end

endmodule

// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule: one C/D register pair and one PC-2 stream K1..K16
// over a valid/ready handshake. DES_KEY_DECRYPT_EN enables K16..K1 ordering.
module des_key_scheduler
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [47:0] round_key,
    output logic [3:0]  round_idx,
    output logic        done
);

    state_e     state_q, state_d;
    half_t      c_half_q, c_half_d;
    half_t      d_half_q, d_half_d;
    logic [4:0] step_q, step_d;
    logic       rk_valid_q, rk_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    round_key_t round_key_q, round_key_d;
    logic [3:0] round_idx_q, round_idx_d;
    logic       load_s;
    logic [55:0] pc1_s;
    round_key_t  pc2_s;

`ifdef DES_KEY_DECRYPT_EN
    logic       dec_q, dec_d;
    logic [3:0] idx_rev_s;
    assign idx_rev_s = 4'd15 - step_q[3:0];
`else
    logic unused_decrypt_s;
    assign unused_decrypt_s = decrypt;
`endif

    assign pc1_s = pc1(key_in);

    // The single PC-2 sees the next C/D so the key registers alongside it.
    des_key_pc2 u_pc2 (
        .cd_i ({c_half_d, d_half_d}),
        .rk_o (pc2_s)
    );

    // Next-state logic: schedule load in IDLE, one step per handshake in RUN.
    always_comb begin
        state_d     = state_q;
        c_half_d    = c_half_q;
        d_half_d    = d_half_q;
        step_d      = step_q;
        rk_valid_d  = rk_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        round_idx_d = round_idx_q;
        load_s      = 1'b0;
`ifdef DES_KEY_DECRYPT_EN
        dec_d       = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    step_d     = 5'd1;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    load_s     = 1'b1;
`ifdef DES_KEY_DECRYPT_EN
                    dec_d = decrypt;
                    // CD16 equals CD0, so decryption starts unrotated.
                    if (decrypt) begin
                        c_half_d    = pc1_s[55:28];
                        d_half_d    = pc1_s[27:0];
                        round_idx_d = 4'd15;
                    end else begin
                        c_half_d    = rotl28(pc1_s[55:28], SHIFT_TBL[0]);
                        d_half_d    = rotl28(pc1_s[27:0], SHIFT_TBL[0]);
                        round_idx_d = 4'd0;
                    end
`else
                    c_half_d    = rotl28(pc1_s[55:28], SHIFT_TBL[0]);
                    d_half_d    = rotl28(pc1_s[27:0], SHIFT_TBL[0]);
                    round_idx_d = 4'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rk_valid_q && rk_ready) begin
                    if (step_q == 5'd16) begin
                        state_d    = ST_IDLE;
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        step_d = step_q + 5'd1;
                        load_s = 1'b1;
`ifdef DES_KEY_DECRYPT_EN
                        if (dec_q) begin
                            c_half_d    = rotr28(c_half_q, SHIFT_TBL[idx_rev_s + 4'd1]);
                            d_half_d    = rotr28(d_half_q, SHIFT_TBL[idx_rev_s + 4'd1]);
                            round_idx_d = idx_rev_s;
                        end else begin
                            c_half_d    = rotl28(c_half_q, SHIFT_TBL[step_q[3:0]]);
                            d_half_d    = rotl28(d_half_q, SHIFT_TBL[step_q[3:0]]);
                            round_idx_d = step_q[3:0];
                        end
`else
                        c_half_d    = rotl28(c_half_q, SHIFT_TBL[step_q[3:0]]);
                        d_half_d    = rotl28(d_half_q, SHIFT_TBL[step_q[3:0]]);
                        round_idx_d = step_q[3:0];
`endif
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign round_key_d = load_s ? pc2_s : round_key_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            c_half_q    <= '0;
            d_half_q    <= '0;
            step_q      <= 5'd0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_key_q <= '0;
            round_idx_q <= 4'd0;
`ifdef DES_KEY_DECRYPT_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            c_half_q    <= c_half_d;
            d_half_q    <= d_half_d;
            step_q      <= step_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
`ifdef DES_KEY_DECRYPT_EN
            dec_q       <= dec_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign rk_valid  = rk_valid_q;
    assign done      = done_q;
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: cumulative-shift reference model,
// per-cycle scoreboard compare, and directed literal checks.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] key_in = 64'h0;
    logic        decrypt = 1'b0;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready = 1'b1;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        done;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [47:0] K1_LIT  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_LIT = 48'hCB3D8B0E17F5;
`ifdef DES_KEY_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam int M_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int M_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                  23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int M_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    des_key_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round key r (1..16) straight from the standard: CDr is CD0 rotated by the running shift total.
    function automatic logic [47:0] model_key(input logic [63:0] key, input int r);
        logic        cd0 [56];
        logic        cdr [56];
        logic [47:0] rk;
        int          tot;
        tot = 0;
        for (int p = 0; p < 56; p++) cd0[p] = key[64 - M_PC1[p]];
        for (int j = 0; j < r; j++) tot += M_SHIFT[j];
        for (int p = 0; p < 28; p++) begin
            cdr[p]      = cd0[(p + tot) % 28];
            cdr[28 + p] = cd0[28 + (p + tot) % 28];
        end
        for (int i = 0; i < 48; i++) rk[47 - i] = cdr[M_PC2[i] - 1];
        return rk;
    endfunction

    task automatic push_schedule(input logic [63:0] key, input logic dec);
        exp_t e;
        int   r;
        for (int k = 0; k < 16; k++) begin
            r = (dec && DEC_EN) ? 16 - k : k + 1;
            e.key = model_key(key, r);
            e.idx = 4'(r - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every cycle, compare outputs with the head of the expected stream.
    int sz;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {busy, rk_valid, done, round_idx, round_key}, 64'h0);
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            sz = exp_q.size();
            check("done", done, exp_done);
            exp_done = 1'b0;
            check("rk_valid", rk_valid, sz > 0);
            check("busy", busy, sz > 0);
            if (sz > 0 && rk_valid) begin
                check("round_key", round_key, exp_q[0].key);
                check("round_idx", round_idx, exp_q[0].idx);
                if (rk_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end else if (sz == 0 && start) begin
                push_schedule(key_in, decrypt);
            end
        end
    end

    task automatic start_sched(input logic [63:0] k, input logic d);
        @(posedge clk); #1;
        key_in  = k;
        decrypt = d;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_latency", rk_valid, 1'b1);
    endtask

    task automatic wait_done(output logic [47:0] lk, output logic [3:0] li);
        bit found;
        found = 1'b0;
        lk = '0;
        li = '0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (rk_valid && rk_ready) begin
                lk = round_key;
                li = round_idx;
            end
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        check("done_seen", found, 1'b1);
    endtask

    task automatic wait_idx(input logic [3:0] idx);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (rk_valid && round_idx == idx) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("idx_reached", found, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] lk;
        logic [3:0]  li;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_key", round_key, 48'h0);
        check("rst_idx", round_idx, 4'd0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;

        check("model_K1", model_key(KEY_A, 1), K1_LIT);
        check("model_K16", model_key(KEY_A, 16), K16_LIT);

        // Encrypt order with rk_ready held high.
        start_sched(KEY_A, 1'b0);
        check("enc_first_key", round_key, K1_LIT);
        check("enc_first_idx", round_idx, 4'd0);
        wait_done(lk, li);
        check("enc_last_key", lk, K16_LIT);
        check("enc_last_idx", li, 4'd15);

        // Decrypt order (encrypt order when the option is compiled out).
        start_sched(KEY_A, 1'b1);
        check("dec_first_key", round_key, DEC_EN ? K16_LIT : K1_LIT);
        check("dec_first_idx", round_idx, DEC_EN ? 4'd15 : 4'd0);
        wait_done(lk, li);
        check("dec_last_key", lk, DEC_EN ? K1_LIT : K16_LIT);
        check("dec_last_idx", li, DEC_EN ? 4'd0 : 4'd15);

        // Backpressure: stall three cycles on K4.
        start_sched(KEY_A, 1'b0);
        wait_idx(4'd3);
        rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_key", round_key, model_key(KEY_A, 4));
        check("bp_hold_idx", round_idx, 4'd3);
        rk_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_resume_key", round_key, model_key(KEY_A, 5));
        check("bp_resume_idx", round_idx, 4'd4);
        wait_done(lk, li);
        check("bp_last_key", lk, K16_LIT);

        // Start with a different key during RUN is ignored.
        start_sched(KEY_A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        key_in = KEY_B;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lk, li);
        check("ignore_last_key", lk, K16_LIT);

        // Asynchronous reset after K7: outputs clear at once, no done.
        start_sched(KEY_A, 1'b0);
        wait_idx(4'd6);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {busy, rk_valid, done, round_idx, round_key}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_rst", done, 1'b0);
        start_sched(KEY_A, 1'b0);
        check("post_rst_K1", round_key, K1_LIT);
        wait_done(lk, li);

        // Back-to-back: start held across done, second key sampled in the done cycle.
        @(posedge clk); #1;
        key_in  = KEY_A;
        decrypt = 1'b0;
        start   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        key_in = KEY_B;
        wait_done(lk, li);
        check("b2b_first_last_key", lk, K16_LIT);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_valid", rk_valid, 1'b1);
        check("b2b_idx", round_idx, 4'd0);
        check("b2b_key", round_key, model_key(KEY_B, 1));
        wait_done(lk, li);
        check("b2b_last_key", lk, model_key(KEY_B, 16));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_scheduler.md
# des_key_scheduler

Iterative DES key-schedule controller: accepts a 64-bit DES key and streams the sixteen 48-bit round keys, one per accepted handshake, in encryption (K1..K16) or decryption (K16..K1) order. It replaces the fully unrolled sixteen-stage key expansion with a single C/D register pair plus one PC-2 instance. It sits between the key-load interface and the iterative round datapath, which consumes round keys through a valid/ready handshake.

## Interface
- No parameters; all constants are fixed by the DES standard.
- One clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new schedule; sampled only in IDLE
- key_in  in  64  DES key incl. parity bits (bit 63 = DES bit 1); sampled with accepted start
- decrypt  in  1  order select, sampled with accepted start: 0 = K1..K16, 1 = K16..K1
- busy  out  1  high from the cycle after an accepted start until the final handshake
- rk_valid  out  1  round_key/round_idx valid
- rk_ready  in  1  consumer accepts the current round key
- round_key  out  48  current round key, PC-2 output, bit 47 = DES bit 1
- round_idx  out  4  index of current key, 0 = K1 .. 15 = K16
- done  out  1  one-cycle pulse after the 16th handshake

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: start=1 → latch CD = PC1(key_in) with the first step applied, register the first key, go to RUN. Accepted start while in RUN is ignored.
- Shift schedule SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D are 28-bit halves, rotated independently.
- Encrypt step j (1..16): rotate C,D left by SHIFT[j]; round_key = PC2(C,D); round_idx = j-1.
- Decrypt step 1: no rotation (CD16 == CD0); round_key = PC2(PC1(key)); round_idx = 15.
- Decrypt step j (2..16): rotate C,D right by SHIFT[18-j]; round_idx = 16-j.
- Handshake: transfer when rk_valid && rk_ready at a rising edge. On transfer, the next step's key is registered at the same edge, so rk_valid stays high: one key per cycle when rk_ready is held high.
- rk_ready low: round_key, round_idx, C, D, and the step counter are held.
- 16th transfer → rk_valid=0, busy=0, done=1 for one cycle, state IDLE. start in that same cycle is accepted normally.
- Step counter: 5 bits, 1..16; no wrap beyond 16.
- Parity bits (DES bits 8,16,…,64) are discarded by PC-1 and never checked.

## Timing
- Reset values: busy=0, rk_valid=0, round_key=0, round_idx=0, done=0; CD and counter cleared.
- Start latency: start sampled at edge T → rk_valid=1 with the first key at T+1.
- Full schedule: 16 cycles with rk_ready tied high; done asserted at edge T+17.
- Reset mid-schedule: outputs return immediately to reset values; the remaining keys are discarded, and no done pulse is generated.
- round_key is registered; there is no combinational path from rk_ready or start to any output.

## Configuration
- DES_KEY_DECRYPT_EN defined: the decrypt input is honoured, and a right-rotate path plus reverse indexing are present.
- DES_KEY_DECRYPT_EN undefined: the decrypt port remains but is ignored, and order is always K1..K16. The right-rotate logic is not compiled.

## Structure
- Shared package des_pkg: SHIFT schedule constant, PC1 and PC2 index tables, 48-bit round-key typedef, 28-bit half typedef, and a state enum.
- Sub-module des_key_pc2: combinational 56→48 PC-2 permutation, instantiated once. PC-1 stays inline as a package function.

## Test plan
- Encrypt, key 133457799BBCDFF1, rk_ready=1: K1=1B02EFFC7072 at T+1, K16=CB3D8B0E17F5 at T+16, round_idx 0..15, done at T+17.
- Decrypt, same key: first key CB3D8B0E17F5 with round_idx=15; last key 1B02EFFC7072 with round_idx=0. Compare all 16 keys against the encrypt run, reversed.
- Backpressure: drop rk_ready for 3 cycles after K4. round_key and round_idx must be stable at K4, then the sequence resumes with K5 and no skip or duplicate.
- Start pulsed during RUN with a different key: ignored, and the original schedule completes unchanged.
- rst_n asserted after K7: all outputs are 0 asynchronously, with no done pulse. A fresh start then produces K1 correctly.
- Back-to-back: start held high across done → new schedule begins, with K1 valid the cycle after done.
